// File: rtl/digital_gain_pkg.sv
// Shared constants and saturation/magnitude helpers for the N-channel digital gain stage.
package digital_gain_pkg;

    localparam int unsigned GAIN_LAT = 3;
    // Helpers work on a fixed wide word; callers extend and slice around them.
    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] sat_signed(input logic [MAX_W-1:0] x,
                                                    input int unsigned w);
        logic signed [MAX_W-1:0] xs, hi, lo;
        xs = $signed(x);
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (xs > hi) begin
            return $unsigned(hi);
        end else if (xs < lo) begin
            return $unsigned(lo);
        end
        return x;
    endfunction

    function automatic logic [MAX_W-1:0] sat_unsigned(input logic [MAX_W-1:0] x,
                                                      input int unsigned w);
        logic [MAX_W-1:0] hi;
        hi = (64'd1 << w) - 64'd1;
        return (x > hi) ? hi : x;
    endfunction

    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] x,
                                                 input logic is_signed);
        return (is_signed && x[MAX_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/digital_gain_nch_lane.sv
// One channel: multiply (S2), round/shift/saturate (S3), plus per-frame peak and clip tracking.
module gain_lane
    import digital_gain_pkg::*;
#(
    parameter int unsigned IN_W      = 32,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned COEF_FRAC = 8,
    parameter bit          IS_SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   data_s1,
    input  logic [COEF_W-1:0] coef,
    input  logic              s1_stat,
    input  logic              s1_first,
    input  logic              s2_en,
    input  logic              s2_stat,
    input  logic              s2_first,
    input  logic              s2_last,
    output logic [OUT_W-1:0]  data_out,
    output logic [IN_W-1:0]   max_out,
    output logic              sat_out
);
    localparam int unsigned PW = IN_W + COEF_W + 1;
    localparam logic [PW-1:0] RND = PW'(1) << (COEF_FRAC - 1);

    logic [PW-1:0]    data_ext, coef_ext, prod_d, prod_q, rnd, sh;
    logic [MAX_W-1:0] wide, clipped, mag_wide;
    logic [IN_W-1:0]  mag, acc_q;
    logic [OUT_W-1:0] out_d;
    logic             clip, sat_acc_q;

    always_comb begin
        data_ext = IS_SIGNED ? {{(PW-IN_W){data_s1[IN_W-1]}}, data_s1}
                             : {{(PW-IN_W){1'b0}}, data_s1};
        coef_ext = {{(PW-COEF_W){1'b0}}, coef};
        prod_d   = data_ext * coef_ext;
        mag_wide = abs_mag(IS_SIGNED ? {{(MAX_W-IN_W){data_s1[IN_W-1]}}, data_s1}
                                     : {{(MAX_W-IN_W){1'b0}}, data_s1}, IS_SIGNED);
        mag      = mag_wide[IN_W-1:0];
    end

    always_comb begin
        rnd = prod_q + RND;
        if (IS_SIGNED) begin
            sh      = $signed(rnd) >>> COEF_FRAC;
            wide    = {{(MAX_W-PW){sh[PW-1]}}, sh};
            clipped = sat_signed(wide, OUT_W);
        end else begin
            sh      = rnd >> COEF_FRAC;
            wide    = {{(MAX_W-PW){1'b0}}, sh};
            clipped = sat_unsigned(wide, OUT_W);
        end
        clip  = (clipped != wide);
        out_d = clipped[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q    <= '0;
            acc_q     <= '0;
            data_out  <= '0;
            sat_acc_q <= 1'b0;
            max_out   <= '0;
            sat_out   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            if (s1_stat) begin
                acc_q <= (s1_first || mag > acc_q) ? mag : acc_q;
            end
            if (s2_en) begin
                data_out <= out_d;
            end
            if (s2_stat) begin
                sat_acc_q <= s2_first ? clip : (sat_acc_q | clip);
            end
            // acc_q already holds the last word here, one cycle after it left S1
            if (s2_last) begin
                max_out <= acc_q;
                sat_out <= sat_acc_q | clip;
            end
        end
    end

endmodule

// File: rtl/digital_gain_nch.sv
// N-channel post-accumulation gain: sync delay line, frame-aligned coefficient shadow, lanes.
module digital_gain_nch
    import digital_gain_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       IN_W        = 32,
    parameter int unsigned       OUT_W       = 16,
    parameter int unsigned       COEF_W      = 16,
    parameter int unsigned       COEF_FRAC   = 8,
    parameter int unsigned       CNT_W       = 9,
    parameter int unsigned       FRAME_LEN   = 512,
    parameter logic [NUM_CH-1:0] SIGNED_MASK = 4'b1100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ms_in,
    input  logic                     en_sync_in,
    input  logic [CNT_W-1:0]         cnt_sync_in,
    input  logic [NUM_CH*COEF_W-1:0] coef_in,
    input  logic [NUM_CH*IN_W-1:0]   data_in,
    output logic                     en_sync_out,
    output logic [CNT_W-1:0]         cnt_sync_out,
    output logic [NUM_CH*OUT_W-1:0]  data_out,
    output logic [NUM_CH*IN_W-1:0]   max_out,
    output logic [NUM_CH-1:0]        sat_out,
    output logic                     stat_valid
);
    localparam logic [COEF_W-1:0] UNITY = COEF_W'(1) << COEF_FRAC;

    logic                     en_pipe  [GAIN_LAT];
    logic [CNT_W-1:0]         cnt_pipe [GAIN_LAT];
    logic [NUM_CH*IN_W-1:0]   data_s1;
    logic [NUM_CH*COEF_W-1:0] coef_shadow;
    logic                     s1_stat, s1_first, s1_last;
    logic                     started_q, s2_stat_q, s2_first_q, s2_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GAIN_LAT; i++) begin
                en_pipe[i]  <= 1'b0;
                cnt_pipe[i] <= '0;
            end
            data_s1     <= '0;
            coef_shadow <= '0;
        end else begin
            en_pipe[0]  <= en_sync_in;
            cnt_pipe[0] <= cnt_sync_in;
            for (int i = 1; i < GAIN_LAT; i++) begin
                en_pipe[i]  <= en_pipe[i-1];
                cnt_pipe[i] <= cnt_pipe[i-1];
            end
            data_s1 <= data_in;
            if (en_sync_in && cnt_sync_in == '0) begin
                coef_shadow <= ms_in ? coef_in : {NUM_CH{UNITY}};
            end
        end
    end

    // A frame only reports if its start was seen since reset.
    always_comb begin
        s1_stat  = en_pipe[0] && (32'(cnt_pipe[0]) < FRAME_LEN);
        s1_first = en_pipe[0] && (cnt_pipe[0] == '0);
        s1_last  = s1_stat && (32'(cnt_pipe[0]) == FRAME_LEN - 1) && started_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q  <= 1'b0;
            s2_stat_q  <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            stat_valid <= 1'b0;
        end else begin
            if (s1_first) begin
                started_q <= 1'b1;
            end
            s2_stat_q  <= s1_stat;
            s2_first_q <= s1_first;
            s2_last_q  <= s1_last;
            stat_valid <= s2_last_q;
        end
    end

    assign en_sync_out  = en_pipe[GAIN_LAT-1];
    assign cnt_sync_out = cnt_pipe[GAIN_LAT-1];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        gain_lane #(
            .IN_W      (IN_W),
            .OUT_W     (OUT_W),
            .COEF_W    (COEF_W),
            .COEF_FRAC (COEF_FRAC),
            .IS_SIGNED (SIGNED_MASK[k])
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .data_s1  (data_s1[k*IN_W +: IN_W]),
            .coef     (coef_shadow[k*COEF_W +: COEF_W]),
            .s1_stat  (s1_stat),
            .s1_first (s1_first),
            .s2_en    (en_pipe[1]),
            .s2_stat  (s2_stat_q),
            .s2_first (s2_first_q),
            .s2_last  (s2_last_q),
            .data_out (data_out[k*OUT_W +: OUT_W]),
            .max_out  (max_out[k*IN_W +: IN_W]),
            .sat_out  (sat_out[k])
        );
    end

endmodule

// File: tb/tb_digital_gain_nch.sv
// Directed bench for digital_gain_nch: bypass, rounding, saturation, frame stats, shadowing, reset.
module tb_digital_gain_nch;
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned FRAME_LEN = 512;

    logic             clk = 1'b0;
    logic             rst, ms_in, en_sync_in;
    logic [CNT_W-1:0] cnt_sync_in;
    logic [63:0]      coef_in;
    logic [127:0]     data_in;
    logic             en_sync_out, stat_valid;
    logic [CNT_W-1:0] cnt_sync_out;
    logic [63:0]      data_out;
    logic [127:0]     max_out;
    logic [3:0]       sat_out;

    int               total = 0;
    int               bad = 0;
    int               sv_cnt = 0;
    int               base;
    logic [CNT_W-1:0] sv_cnt_at;
    logic             sv_en;
    logic [127:0]     sv_max;
    logic [3:0]       sv_sat;
    logic [15:0]      out0 [FRAME_LEN];

    always #5 clk = ~clk;

    digital_gain_nch dut (
        .clk          (clk),
        .rst          (rst),
        .ms_in        (ms_in),
        .en_sync_in   (en_sync_in),
        .cnt_sync_in  (cnt_sync_in),
        .coef_in      (coef_in),
        .data_in      (data_in),
        .en_sync_out  (en_sync_out),
        .cnt_sync_out (cnt_sync_out),
        .data_out     (data_out),
        .max_out      (max_out),
        .sat_out      (sat_out),
        .stat_valid   (stat_valid)
    );

    always @(negedge clk) begin
        if (stat_valid) begin
            sv_cnt    <= sv_cnt + 1;
            sv_cnt_at <= cnt_sync_out;
            sv_en     <= en_sync_out;
            sv_max    <= max_out;
            sv_sat    <= sat_out;
        end
        if (en_sync_out) begin
            out0[cnt_sync_out] <= data_out[15:0];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic en, input int cnt, input logic [15:0] coef,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
        en_sync_in  = en;
        cnt_sync_in = CNT_W'(cnt);
        coef_in     = {4{coef}};
        data_in     = {d3, d2, d1, d0};
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_word(1'b0, 0, 16'h0, 0, 0, 0, 0);
    endtask

    // ch0 = c, ch1 = c or a clipping spike, ch2 = -c, ch3 = c with -5000 at 37; gaps carry junk
    task automatic send_frame(input int first, input int last, input logic [15:0] coef0,
                              input int switch_at, input logic [15:0] coef1,
                              input int sat_at, input bit gaps);
        logic [15:0] cf;
        for (int c = first; c <= last; c++) begin
            cf = (c >= switch_at) ? coef1 : coef0;
            if (gaps && (c == 100 || c == 400)) begin
                send_word(1'b0, c, cf, 32'h7fff_ffff, 32'hffff_ffff, 32'h8000_0000, 32'h8000_0000);
            end
            send_word(1'b1, c, cf, c, (c == sat_at) ? 32'h0010_0000 : c, -c,
                      (c == 37) ? -5000 : c);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ms_in = 1'b0; en_sync_in = 1'b0; cnt_sync_in = '0; coef_in = '0; data_in = '0;
        step();
        step();
        check("rst_data", data_out, 0);
        check("rst_en", en_sync_out, 0);
        check("rst_max", max_out, 0);
        check("rst_sat", sat_out, 0);
        check("rst_sv", stat_valid, 0);
        rst = 1'b0;

        // Bypass: coef_in ignored, gain forced to 1.0
        ms_in = 1'b0;
        send_word(1'b1, 0, 16'h0180, 1000, 0, -1000, 0);
        check("lat1_en", en_sync_out, 0);
        idle(1);
        check("lat2_en", en_sync_out, 0);
        idle(1);
        check("lat3_en", en_sync_out, 1);
        check("lat3_cnt", cnt_sync_out, 0);
        check("unity_ch0", data_out[15:0], 16'd1000);
        check("unity_ch2", data_out[47:32], 16'hfc18);
        idle(1);
        check("lat4_en", en_sync_out, 0);
        check("hold_ch0", data_out[15:0], 16'd1000);

        // Gain 1.5 with half-up rounding and both saturation directions
        ms_in = 1'b1;
        send_word(1'b1, 0, 16'h0180, 101, 32'h0010_0000, -101, 32'h8000_0000);
        idle(2);
        check("gain_u_round", data_out[15:0], 16'd152);
        check("gain_u_sat", data_out[31:16], 16'hffff);
        check("gain_s_round", data_out[47:32], 16'hff69);
        check("gain_s_sat", data_out[63:48], 16'h8000);

        // Full frame with gaps, no clipping
        base = sv_cnt;
        send_frame(0, 511, 16'h0100, 9999, 16'h0100, -1, 1'b1);
        idle(4);
        check("b_pulses", sv_cnt - base, 1);
        check("b_pulse_cnt", sv_cnt_at, 511);
        check("b_pulse_en", sv_en, 1);
        check("b_max_ch0", sv_max[31:0], 511);
        check("b_max_ch2", sv_max[95:64], 511);
        check("b_max_ch3", sv_max[127:96], 5000);
        check("b_sat", sv_sat, 0);
        check("b_last_out", data_out[15:0], 16'd511);

        // Full frame with one clipping word on unsigned ch1
        base = sv_cnt;
        send_frame(0, 511, 16'h0100, 9999, 16'h0100, 50, 1'b0);
        idle(4);
        check("a_pulses", sv_cnt - base, 1);
        check("a_sat", sv_sat, 4'b0010);
        check("a_max_ch1", sv_max[63:32], 32'h0010_0000);
        check("a_max_ch3", sv_max[127:96], 5000);

        // coef_in doubles at cnt 200; shadow keeps 1.0 for the rest of this frame
        send_frame(0, 511, 16'h0100, 200, 16'h0200, 50, 1'b0);
        idle(4);
        check("c_old_199", out0[199], 16'd199);
        check("c_old_250", out0[250], 16'd250);

        // Next frame picks up 2.0 from its first word; reset lands at cnt 300
        send_frame(0, 300, 16'h0200, 9999, 16'h0200, -1, 1'b0);
        check("d_new_0", out0[0], 16'd0);
        check("d_new_5", out0[5], 16'd10);
        check("d_pre_rst_sat", sat_out, 4'b0010);
        rst = 1'b1;
        #1;
        check("mid_rst_data", data_out, 0);
        check("mid_rst_en", en_sync_out, 0);
        check("mid_rst_cnt", cnt_sync_out, 0);
        check("mid_rst_max", max_out, 0);
        check("mid_rst_sat", sat_out, 0);
        rst = 1'b0;

        base = sv_cnt;
        send_frame(301, 511, 16'h0100, 9999, 16'h0100, -1, 1'b0);
        idle(4);
        check("partial_pulses", sv_cnt - base, 0);
        check("partial_max", max_out, 0);

        base = sv_cnt;
        send_frame(0, 511, 16'h0100, 9999, 16'h0100, -1, 1'b1);
        idle(4);
        check("e_pulses", sv_cnt - base, 1);
        check("e_max_ch3", sv_max[127:96], 5000);
        check("e_max_ch0", sv_max[31:0], 511);
        check("e_sat", sv_sat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digital_gain_nch.md
Name: digital_gain_nch

Overview:
- Parametrised N-channel post-accumulation digital gain stage. Sits after the Stokes/power integrators and before output packing.
- Each channel multiplies a wide accumulated word by its own gain coefficient, rounds, and saturates to OUT_W. Signed and unsigned channels are mixed through a per-channel mode mask.
- Per-frame peak magnitude and saturation flags are reported per channel. The sync enable/counter is delayed to stay aligned with the data.

Parameters:
- NUM_CH, 4, number of channels (I,Q,U,V by default)
- IN_W, 32, input word width per channel
- OUT_W, 16, output word width per channel
- COEF_W, 16, unsigned gain coefficient width
- COEF_FRAC, 8, fractional bits of the coefficient (gain = coef / 2^COEF_FRAC)
- CNT_W, 9, width of the sync counter
- FRAME_LEN, 512, spectral points per frame; 2 <= FRAME_LEN <= 2^CNT_W
- SIGNED_MASK, 4'b1100, bit k = 1 means channel k is two's complement, 0 means unsigned

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ms_in  in  1  1 = apply gain; 0 = bypass (coefficient forced to 1.0)
- en_sync_in  in  1  input data valid
- cnt_sync_in  in  CNT_W  point index of the current input word
- coef_in  in  NUM_CH*COEF_W  packed coefficients; channel k is at bits [k*COEF_W +: COEF_W]
- data_in  in  NUM_CH*IN_W  packed input words
- en_sync_out  out  1  en_sync_in delayed by 3 cycles
- cnt_sync_out  out  CNT_W  cnt_sync_in delayed by 3 cycles
- data_out  out  NUM_CH*OUT_W  packed gained, saturated outputs
- max_out  out  NUM_CH*IN_W  per-channel peak |input| of the last completed frame
- sat_out  out  NUM_CH  per-channel flag: saturation occurred in the last completed frame
- stat_valid  out  1  one-cycle pulse when max_out and sat_out update

Behaviour:
- Reset: all pipeline registers, en_sync_out, cnt_sync_out, data_out, max_out, sat_out, stat_valid, shadow coefficients and accumulators go to 0. Reset takes effect immediately, including mid-frame. The first statistics after reset come from the first complete frame (start at cnt=0).
- Coefficient shadowing: the shadow coefficients load from coef_in (or 1<<COEF_FRAC when ms_in=0) only on a cycle with en_sync_in=1 and cnt_sync_in=0. That cycle's data already uses the new value. Gain is therefore constant within a frame; ms_in changes also take effect only at a frame start.
- Pipeline, fixed latency 3, advancing every cycle regardless of enable:
  - S1: register the inputs.
  - S2: product = data × shadow coefficient. Signed channels use a signed multiply with the coefficient zero-extended; width is IN_W+COEF_W+1.
  - S3: round half-up (add 1<<(COEF_FRAC-1)), arithmetic or logical shift right by COEF_FRAC, then saturate.
    - Signed channels clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - Unsigned channels clip to [0, 2^OUT_W-1].
- data_out holds its last value when en_sync_out=0; the register updates only on valid.
- Peak tracking on S1 data with en=1:
  - Magnitude is |x| for signed channels and x for unsigned channels.
  - The most negative signed input maps to 2^(IN_W-1), which fits in IN_W bits as unsigned.
  - At cnt=0 the accumulator is set to the current magnitude (frame restart); otherwise acc = max(acc, mag).
- Saturation flag: set on a valid S3 word that clipped; reset to that word's clip result when its cnt=0.
- Frame end: the valid word with cnt=FRAME_LEN-1 completes the frame.
  - max_out updates, including that word, 1 cycle after it leaves S1.
  - sat_out updates when the same word leaves S3.
  - stat_valid pulses with the sat_out update; max_out is stable by then.
- Gaps (en=0) inside a frame are allowed and change nothing. A frame start seen before FRAME_LEN-1 restarts the accumulators; no stat_valid is issued for the truncated frame.
- Counter values >= FRAME_LEN are passed through but ignored for statistics.

Decomposition:
- Package digital_gain_pkg holds:
  - the latency constant GAIN_LAT=3;
  - functions sat_signed(), sat_unsigned() and abs_mag().
- One sub-module, gain_lane: a single channel's S2/S3 datapath plus its peak/saturation tracking, with the signedness as a parameter. The top generates NUM_CH lanes and owns the sync delay line, shadow load and stat_valid.

Test Plan:
- Unity bypass: ms_in=0, data_in ch0=1000, ch2=-1000 -> 3 cycles later data_out ch0=1000, ch2=-1000; en/cnt delayed exactly 3.
- Gain and rounding: coef=0x0180 (1.5), unsigned input 101 -> 152 (151.5 rounds up). Signed input -101 -> -151 (-151.5 rounds half-up).
- Saturation: unsigned input 0x0010_0000 with coef 0x0100 -> 0xFFFF, sat_out bit set at frame end. Signed input -2^31 -> 0x8000.
- Frame stats: 512-point frame with ch3 peak at -5000, cnt=37, plus two en=0 gaps -> stat_valid once; max_out ch3=5000, sat_out=0.
- Mid-frame coefficient change: coef_in changes at cnt=200 -> outputs keep the old gain until the next cnt=0, then switch on that word.
- Reset mid-frame at cnt=300 -> all outputs 0 immediately. The partial frame ends at cnt=511 with no stat_valid; the next full frame reports correctly.
